// File: rtl/rks_loader.sv
// rks_loader: streaming parser for .RKS tape images arriving from data_io.
// Strips the 4-byte header (start lo/hi, end lo/hi), writes each body byte
// to RAM at its target address, then consumes a 2-byte checksum (high first).
// Optional feature macro: RKS_CHECKSUM_EN enables checksum computation and
// comparison. Without it the trailing 2 bytes are consumed and ignored.
//
// state  | meaning
// S_IDLE | waiting for the active condition to rise
// S_HDR  | collecting 4 header bytes
// S_BODY | writing body bytes, start_addr..end_addr
// S_CSUM | collecting 2 checksum bytes
// S_DONE | image accepted, ignoring bytes until download ends
// S_ERR  | image rejected, ignoring bytes until download ends

module rks_loader #(
    parameter logic [4:0] RKS_INDEX = 5'd1,
    parameter logic [8:0] PAGE      = 9'd0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [4:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_data,
    output logic        ram_we,
    output logic [24:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] start_addr,
    output logic [15:0] end_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BODY,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    logic        act;
    logic        act_rise;
    logic        act_fall;

    logic        act_q,     act_d;
    logic        wr_s_q,    wr_s_d;
    logic        wr_prev_q, wr_prev_d;
    logic        byte_ev_q, byte_ev_d;
    logic [7:0]  data_q,    data_d;

    state_t      state_q,   state_d;
    logic [1:0]  cnt_q,     cnt_d;
    logic [7:0]  hdr_lo_q,  hdr_lo_d;
    logic [15:0] start_q,   start_d;
    logic [15:0] end_q,     end_d;
    logic [15:0] tgt_q,     tgt_d;
    logic        ram_we_q,  ram_we_d;
    logic [24:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic        done_q,    done_d;
    logic        err_q,     err_d;
`ifdef RKS_CHECKSUM_EN
    logic [15:0] cs_q,      cs_d;
    logic [7:0]  cs_hi_q,   cs_hi_d;
`endif

    logic [15:0] hdr_word;

    assign act      = ioctl_download && (ioctl_index == RKS_INDEX);
    assign act_rise = act && !act_q;
    assign act_fall = !act && act_q;
    assign hdr_word = {data_q, hdr_lo_q};

    // Input stage: sample ioctl_wr, detect its rising edge, latch the byte.
    always_comb begin
        act_d     = act;
        wr_s_d    = ioctl_wr;
        wr_prev_d = wr_s_q;
        byte_ev_d = wr_s_q && !wr_prev_q && act;
        data_d    = (wr_s_q && !wr_prev_q) ? ioctl_data : data_q;
    end

    // Input stage registers; act_q follows act through reset so that a reset
    // in the middle of a download does not look like a fresh download start.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            act_q     <= act_d;
            wr_s_q    <= 1'b0;
            wr_prev_q <= 1'b0;
            byte_ev_q <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            act_q     <= act_d;
            wr_s_q    <= wr_s_d;
            wr_prev_q <= wr_prev_d;
            byte_ev_q <= byte_ev_d;
            data_q    <= data_d;
        end
    end

    // Parser next-state and datapath; a dropped download always wins over a byte.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_lo_d   = hdr_lo_q;
        start_d    = start_q;
        end_d      = end_q;
        tgt_d      = tgt_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef RKS_CHECKSUM_EN
        cs_d       = cs_q;
        cs_hi_d    = cs_hi_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (act_rise) begin
                    state_d = S_HDR;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = 2'd0;
`ifdef RKS_CHECKSUM_EN
                    cs_d    = 16'h0000;
`endif
                end
            end

            S_HDR: begin
                if (act_fall) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (byte_ev_q) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0: hdr_lo_d = data_q;
                        2'd1: start_d  = hdr_word;
                        2'd2: hdr_lo_d = data_q;
                        default: begin
                            end_d = hdr_word;
                            if (hdr_word < start_q) begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_BODY;
                                tgt_d   = start_q;
                            end
                        end
                    endcase
                end
            end

            S_BODY: begin
                if (act_fall) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (byte_ev_q) begin
                    ram_we_d   = act;
                    ram_addr_d = {PAGE, tgt_q};
                    ram_din_d  = data_q;
                    if (tgt_q == end_q) begin
                        state_d = S_CSUM;
                        cnt_d   = 2'd0;
`ifdef RKS_CHECKSUM_EN
                        cs_d    = cs_q + {8'h00, data_q};
`endif
                    end else begin
                        tgt_d   = tgt_q + 16'd1;
`ifdef RKS_CHECKSUM_EN
                        cs_d    = cs_q + {data_q, data_q};
`endif
                    end
                end
            end

            S_CSUM: begin
                if (act_fall) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (byte_ev_q) begin
                    if (cnt_q == 2'd0) begin
                        cnt_d   = 2'd1;
`ifdef RKS_CHECKSUM_EN
                        cs_hi_d = data_q;
`endif
                    end else begin
`ifdef RKS_CHECKSUM_EN
                        if ({cs_hi_q, data_q} == cs_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end

            S_DONE, S_ERR: begin
                if (!act) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Parser registers; reset also drops any write computed for this cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            hdr_lo_q   <= 8'h00;
            start_q    <= 16'h0000;
            end_q      <= 16'h0000;
            tgt_q      <= 16'h0000;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 25'd0;
            ram_din_q  <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef RKS_CHECKSUM_EN
            cs_q       <= 16'h0000;
            cs_hi_q    <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_lo_q   <= hdr_lo_d;
            start_q    <= start_d;
            end_q      <= end_d;
            tgt_q      <= tgt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef RKS_CHECKSUM_EN
            cs_q       <= cs_d;
            cs_hi_q    <= cs_hi_d;
`endif
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign busy       = (state_q == S_HDR) || (state_q == S_BODY) || (state_q == S_CSUM);
    assign done       = done_q;
    assign err        = err_q;
    assign start_addr = start_q;
    assign end_addr   = end_q;

endmodule

// File: tb/tb_rks_loader.sv
// tb_rks_loader: directed and randomized .RKS images against a reference model.
module tb_rks_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [4:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_data;
    logic        ram_we;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] start_addr;
    logic [15:0] end_addr;

    always #10 clk_sys = ~clk_sys;

    rks_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_data     (ioctl_data),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .start_addr     (start_addr),
        .end_addr       (end_addr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: records every RAM write and flags protocol violations.
    logic [24:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    int          we_outside = 0;
    int          we_long    = 0;
    logic        we_prev    = 1'b0;

    always @(negedge clk_sys) begin
        if (ram_we) begin
            wq_addr.push_back(ram_addr);
            wq_data.push_back(ram_din);
            if (!ioctl_download) we_outside++;
            if (we_prev) we_long++;
        end
        we_prev = ram_we;
    end

    // Reference model state that persists between downloads.
    logic [15:0] m_start = 16'h0;
    logic [15:0] m_end   = 16'h0;
    logic        m_done  = 1'b0;
    logic        m_err   = 1'b0;

    // One byte event, 16 cycles apart; returns cycles until the first ram_we seen.
    task automatic send_byte(input logic [7:0] b, output int lat);
        lat        = -1;
        ioctl_data = b;
        ioctl_wr   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_sys);
            if (k == 4) ioctl_wr = 1'b0;
            if (ram_we && lat < 0) lat = k;
        end
    endtask

    // Build an image: header, body, 16-bit checksum (optionally corrupted in its low byte).
    task automatic build(input logic [15:0] s, input logic [15:0] e, input logic [7:0] body[$],
                         input bit good, output logic [7:0] img[$]);
        int sum;
        img.delete();
        img.push_back(s[7:0]);
        img.push_back(s[15:8]);
        img.push_back(e[7:0]);
        img.push_back(e[15:8]);
        sum = 0;
        foreach (body[i]) begin
            img.push_back(body[i]);
            sum += (i == body.size() - 1) ? int'(body[i]) : int'(body[i]) * 257;
        end
        sum = sum % 65536;
        img.push_back(8'((sum / 256) % 256));
        img.push_back(8'(sum % 256) ^ (good ? 8'h00 : 8'h01));
    endtask

    task automatic run_image(input logic [7:0] img[$], input int nsent, input logic [4:0] idx,
                             input string name);
        logic [24:0] ea[$];
        logic [7:0]  ed[$];
        bit          fin;
        int          len, nb, sum, rx, lat, lat_first;
        fin = 0;
        lat_first = -1;
        if (idx == 5'd1) begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (nsent >= 2) m_start = {img[1], img[0]};
            if (nsent >= 4) m_end   = {img[3], img[2]};
            if (nsent < 4) begin
                m_err = 1'b1;
            end else if (m_end < m_start) begin
                m_err = 1'b1;
                fin   = 1;
            end else begin
                len = int'(m_end) - int'(m_start) + 1;
                nb  = (nsent - 4 < len) ? nsent - 4 : len;
                for (int i = 0; i < nb; i++) begin
                    ea.push_back(25'(int'(m_start) + i));
                    ed.push_back(img[4 + i]);
                end
                if (nsent < 4 + len + 2) begin
                    m_err = 1'b1;
                end else begin
                    fin = 1;
                    sum = 0;
                    for (int i = 0; i < len; i++)
                        sum += (i == len - 1) ? int'(img[4 + i]) : int'(img[4 + i]) * 257;
                    sum = sum % 65536;
                    rx  = int'(img[4 + len]) * 256 + int'(img[5 + len]);
`ifdef RKS_CHECKSUM_EN
                    m_done = (rx == sum);
                    m_err  = (rx != sum);
`else
                    m_done = 1'b1;
`endif
                end
            end
        end

        wq_addr.delete();
        wq_data.delete();
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        repeat (4) @(negedge clk_sys);
        for (int i = 0; i < nsent; i++) begin
            send_byte(img[i], lat);
            if (i == 4) lat_first = lat;
        end
        check({name, " busy_mid"}, 32'(busy), 32'((idx == 5'd1) && !fin));
        if (ea.size() > 0) check({name, " we_latency"}, 32'(lat_first), 32'd3);
        ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);

        check({name, " n_writes"}, 32'(wq_addr.size()), 32'(ea.size()));
        foreach (ea[i]) begin
            if (i < wq_addr.size()) begin
                check({name, " wr_addr"}, 32'(wq_addr[i]), 32'(ea[i]));
                check({name, " wr_data"}, 32'(wq_data[i]), 32'(ed[i]));
            end
        end
        check({name, " done"},  32'(done),       32'(m_done));
        check({name, " err"},   32'(err),        32'(m_err));
        check({name, " busy"},  32'(busy),       32'd0);
        check({name, " start"}, 32'(start_addr), 32'(m_start));
        check({name, " end"},   32'(end_addr),   32'(m_end));
    endtask

    logic [7:0] body[$];
    logic [7:0] img[$];
    int         lat, nw;
    logic [15:0] s, e;
    int         len, total, nsent;

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 5'd1;
        ioctl_wr       = 1'b0;
        ioctl_data     = 8'h00;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst ram_we",   32'(ram_we),     32'd0);
        check("rst busy",     32'(busy),       32'd0);
        check("rst done",     32'(done),       32'd0);
        check("rst err",      32'(err),        32'd0);
        check("rst start",    32'(start_addr), 32'd0);
        check("rst end",      32'(end_addr),   32'd0);
        check("rst ram_addr", 32'(ram_addr),   32'd0);
        check("rst ram_din",  32'(ram_din),    32'd0);

        body = '{8'h11, 8'h22, 8'h33, 8'h44};
        build(16'h4000, 16'h4003, body, 1'b1, img);
        run_image(img, img.size(), 5'd1, "valid");

        build(16'h4000, 16'h4003, body, 1'b0, img);
        run_image(img, img.size(), 5'd1, "bad_csum");

        build(16'h5000, 16'h4FFF, body, 1'b1, img);
        run_image(img, img.size(), 5'd1, "hdr_order");

        build(16'h4000, 16'h4003, body, 1'b1, img);
        run_image(img, 6, 5'd1, "drop_body");

        body = '{8'hA5};
        build(16'hFFFF, 16'hFFFF, body, 1'b1, img);
        run_image(img, img.size(), 5'd1, "len1_top");

        // Reset in the middle of the body: outputs clear, later bytes ignored.
        body = '{8'h11, 8'h22, 8'h33, 8'h44};
        build(16'h4000, 16'h4003, body, 1'b1, img);
        wq_addr.delete();
        wq_data.delete();
        ioctl_index    = 5'd1;
        ioctl_download = 1'b1;
        repeat (4) @(negedge clk_sys);
        for (int i = 0; i < 5; i++) send_byte(img[i], lat);
        check("rstmid first_write", 32'(wq_addr.size()), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        m_start = 16'h0;
        m_end   = 16'h0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        check("rstmid ram_we",   32'(ram_we),     32'd0);
        check("rstmid busy",     32'(busy),       32'd0);
        check("rstmid start",    32'(start_addr), 32'd0);
        check("rstmid end",      32'(end_addr),   32'd0);
        check("rstmid ram_addr", 32'(ram_addr),   32'd0);
        check("rstmid ram_din",  32'(ram_din),    32'd0);
        for (int i = 5; i < img.size(); i++) send_byte(img[i], lat);
        ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("rstmid no_more_writes", 32'(wq_addr.size()), 32'd1);
        check("rstmid done", 32'(done), 32'd0);
        check("rstmid err",  32'(err),  32'd0);
        run_image(img, img.size(), 5'd1, "after_rst");

        run_image(img, img.size(), 5'd2, "fdd_index");

        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(1, 6);
            s   = 16'($urandom_range(1, 16'hFFF0));
            e   = s + 16'(len - 1);
            if ($urandom_range(0, 99) < 15) e = s - 16'd1;
            body.delete();
            for (int i = 0; i < len; i++) body.push_back(8'($urandom));
            build(s, e, body, $urandom_range(0, 99) < 70, img);
            total = img.size();
            if ($urandom_range(0, 99) < 25) nsent = $urandom_range(0, total - 1);
            else nsent = total + $urandom_range(0, 1);
            if (nsent > total) img.push_back(8'($urandom));
            run_image(img, nsent, 5'd1, "rand");
        end

        check("we_outside_download", 32'(we_outside), 32'd0);
        check("we_single_cycle",     32'(we_long),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rks_loader.md
# rks_loader

Streaming parser for `.RKS` tape images delivered by the ARM loader (`data_io`) during a download with the RKS menu index. It sits between `data_io` and the `sram` write port. It strips the 4-byte header, writes each body byte to its target CPU address in RAM, and checks the trailing checksum. It reports the program's start and end addresses to the top level, which uses them for auto-start and status.

## Interface
Parameters:
- `RKS_INDEX`, default 1: `ioctl_index` value that selects RKS parsing.
- `PAGE`, default 0: RAM page placed in `ram_addr[24:16]` for MX model targets.

Ports:
- `clk_sys`  in  1: 48 MHz system clock. One clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `ioctl_download`  in  1: download in progress.
- `ioctl_index`  in  5: selected file type.
- `ioctl_wr`  in  1: byte strobe, level from the `clk_io` domain (at least 2 `clk_sys` cycles high).
- `ioctl_data`  in  8: byte value, stable while `ioctl_wr` is high.
- `ram_we`  out  1: one-cycle RAM write strobe.
- `ram_addr`  out  25: `{PAGE[8:0], target[15:0]}`.
- `ram_din`  out  8: byte to write.
- `busy`  out  1: parse in progress.
- `done`  out  1: image accepted; held until next download start or reset.
- `err`  out  1: image rejected; held until next download start or reset.
- `start_addr`  out  16: header start address.
- `end_addr`  out  16: header end address.

## Operation
- Active only while `ioctl_download && ioctl_index == RKS_INDEX`.
- Byte event: rising edge of `ioctl_wr`, detected by a registered previous value.
- States:
  - IDLE: on rising edge of the active condition → HDR; clear `done`, `err`, byte counter, checksum.
  - HDR: 4 byte events in order: start low, start high, end low, end high. After the 4th:
    - `end_addr < start_addr` → ERR.
    - Otherwise → BODY, with target = `start_addr`.
  - BODY: each byte event writes `ram_din = byte` at target, then target increments.
    - The byte written when target == `end_addr` is the last body byte.
    - After it, → CSUM.
    - Length = `end_addr - start_addr + 1`, range 1..65536.
    - Target is 16-bit; it never wraps because `end_addr` ≥ `start_addr`.
  - CSUM: 2 byte events, high byte first.
    - Received value == computed → DONE, otherwise → ERR.
  - DONE / ERR: further byte events are ignored and produce no writes. Falling edge of the active condition → IDLE, with `done`/`err` held.
- Download ends (active condition falls) while in HDR, BODY or CSUM → ERR, then IDLE with `err=1`.
- Checksum is 16-bit, wraps modulo 65536, initial value 0:
  - Each body byte except the last: `cs += {b, b}`.
  - Last body byte: `cs += {8'h00, b}`.
- `busy` = state ∈ {HDR, BODY, CSUM}.
- Reset at any time:
  - → IDLE.
  - `ram_we=0`, `busy=0`, `done=0`, `err=0`, `start_addr=0`, `end_addr=0`, `ram_addr=0`, `ram_din=0`.
  - A RAM write scheduled for the cycle of reset is suppressed.

## Timing
- `ram_we` is high for exactly 1 `clk_sys` cycle, 2 cycles after the `ioctl_wr` rising edge is sampled:
  - cycle 0: sample;
  - cycle 1: edge detected, registers loaded;
  - cycle 2: `ram_we`.
- `ram_addr` and `ram_din` are stable from cycle 2 until the next byte event.
- Minimum byte spacing is 4 `clk_sys` cycles; the loader guarantees more (≥16).
- `start_addr` and `end_addr` update 1 cycle after the header byte event that completes them.
- `done`/`err` assert 1 cycle after the final CSUM byte event, or after the falling edge of the active condition.
- The top level muxes `ram_*` onto `sram` only while `ioctl_download`. The block never asserts `ram_we` outside that window.

## Configuration
- `RKS_CHECKSUM_EN` defined:
  - Checksum computed and compared as above.
  - Mismatch → ERR.
- Not defined:
  - No checksum logic is compiled.
  - CSUM consumes 2 bytes and always → DONE.
  - An image truncated inside CSUM still → ERR.

## Test plan
- Valid image: header `00 40 03 40` (start=0x4000, end=0x4003), body `11 22 33 44`, then the correct checksum →
  - exactly 4 `ram_we` pulses at 0x4000..0x4003 with the body data;
  - `done=1`, `err=0`, `start_addr=0x4000`, `end_addr=0x4003`.
- Same image with the checksum's low byte flipped:
  - with `RKS_CHECKSUM_EN` → `err=1`, `done=0`, all 4 body writes still issued;
  - without it → `done=1`.
- Header with start=0x5000, end=0x4FFF → `err=1` after byte 4, zero `ram_we` pulses.
- Download dropped after 2 of 4 body bytes → 2 writes, then `err=1`, `busy=0`.
- `reset` asserted in BODY after 1 write → all outputs 0 next cycle, no further writes. A fresh valid download then completes with `done=1`.
- Download with `ioctl_index=2` (FDD image) → no `ram_we`, `busy` stays 0.
